// File: rtl/uart_tx_gen2_if.sv
// Bundle of control/status signals between the APB register block and uart_tx_gen2.
//   master : register block side; drives the ctrl_* strobes and configuration,
//            observes tx_* status and the serial line.
//   slave  : transmitter side; receives ctrl_*, drives tx_* and uart_tx.
interface uart_tx_gen2_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic              ctrl_en;
    logic              ctrl_wr;
    logic [DATA_W-1:0] ctrl_data;
    logic [3:0]        ctrl_dbits;
    logic [1:0]        ctrl_par;
    logic              ctrl_stop;
    logic              ctrl_brk;
    logic              ctrl_tick;
    logic [AW:0]       ctrl_thr;
    logic              ctrl_ovf_clr;

    logic [AW:0]       tx_count;
    logic              tx_nf;
    logic              tx_txe;
    logic              tx_busy;
    logic              tx_ovf;
    logic              uart_tx;

    modport master (
        output ctrl_en, ctrl_wr, ctrl_data, ctrl_dbits, ctrl_par, ctrl_stop,
               ctrl_brk, ctrl_tick, ctrl_thr, ctrl_ovf_clr,
        input  tx_count, tx_nf, tx_txe, tx_busy, tx_ovf, uart_tx
    );

    modport slave (
        input  ctrl_en, ctrl_wr, ctrl_data, ctrl_dbits, ctrl_par, ctrl_stop,
               ctrl_brk, ctrl_tick, ctrl_thr, ctrl_ovf_clr,
        output tx_count, tx_nf, tx_txe, tx_busy, tx_ovf, uart_tx
    );
endinterface

// File: rtl/uart_tx_gen2.sv
// Second-generation UART transmitter: TX FIFO, runtime character length / parity /
// stop-bit selection, back-to-back framing, break generation, sticky overflow flag.
// Ports:
//   pclk   : clock, all logic on rising edge
//   preset : synchronous active-high reset
//   bus    : uart_tx_gen2_if.slave (ctrl_* inputs, tx_* status, uart_tx line)
module uart_tx_gen2 #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input logic           pclk,
    input logic           preset,
    uart_tx_gen2_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    // Bits following the start bit: data, parity and up to two stop bits.
    localparam int FW = DATA_W + 3;

    typedef enum logic [1:0] {IDLE, SHIFT, BREAK} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wptr, rptr, count;
    logic              full, empty, wr_ok, ovf_set, load, ovf;
    logic [FW-1:0]     shreg, frame;
    logic [3:0]        bit_cnt, frame_cnt, n_eff;
    logic [DATA_W-1:0] head;
    logic              par_acc, par_bit, par_en;
    logic              uart_tx_q;

    assign count   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign wr_ok   = bus.ctrl_en && bus.ctrl_wr && !full;
    assign ovf_set = bus.ctrl_en && bus.ctrl_wr && full;
    assign head    = mem[rptr[AW-1:0]];

    // A pop happens only when a frame is loaded: from IDLE, or on the tick that
    // ends the final stop bit.
    assign load = bus.ctrl_en && bus.ctrl_tick && !bus.ctrl_brk && !empty &&
                  ((state == IDLE) || ((state == SHIFT) && (bit_cnt == 4'd0)));

    // Frame image for the FIFO head under the current configuration. Unused
    // upper positions default to 1 so the stop bits fall out naturally.
    always_comb begin
        if (bus.ctrl_dbits < 4'd5) begin
            n_eff = 4'd5;
        end else if (bus.ctrl_dbits > 4'(DATA_W)) begin
            n_eff = 4'(DATA_W);
        end else begin
            n_eff = bus.ctrl_dbits;
        end
        frame   = '1;
        par_acc = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(n_eff)) begin
                frame[i] = head[i];
                par_acc  = par_acc ^ head[i];
            end
        end
        par_en  = (bus.ctrl_par != 2'b00);
        par_bit = 1'b1;
        unique case (bus.ctrl_par)
            2'b00: par_bit = 1'b1;
            2'b01: par_bit = par_acc;
            2'b10: par_bit = ~par_acc;
            2'b11: par_bit = 1'b1;
        endcase
        if (par_en) begin
            frame[n_eff] = par_bit;
        end
        // Bits remaining after the start bit: N + P + S.
        frame_cnt = n_eff + {3'b000, par_en} + {3'b000, bus.ctrl_stop} + 4'd1;
    end

    always_ff @(posedge pclk) begin
        if (wr_ok) begin
            mem[wptr[AW-1:0]] <= bus.ctrl_data;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (bus.ctrl_ovf_clr) begin
                ovf <= 1'b0;
            end
            if (!bus.ctrl_en) begin
                // Flush: empty the FIFO first, then return the pointers to zero.
                if (rptr != wptr) begin
                    rptr <= wptr;
                end else begin
                    rptr <= '0;
                    wptr <= '0;
                end
            end else begin
                if (wr_ok) begin
                    wptr <= wptr + 1'b1;
                end
                if (load) begin
                    rptr <= rptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset || !bus.ctrl_en) begin
            state     <= IDLE;
            uart_tx_q <= 1'b1;
            bit_cnt   <= 4'd0;
            shreg     <= '1;
        end else if (load) begin
            state     <= SHIFT;
            uart_tx_q <= 1'b0;
            shreg     <= frame;
            bit_cnt   <= frame_cnt;
        end else if (bus.ctrl_tick) begin
            case (state)
                IDLE: begin
                    if (bus.ctrl_brk) begin
                        state     <= BREAK;
                        uart_tx_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_cnt != 4'd0) begin
                        uart_tx_q <= shreg[0];
                        shreg     <= {1'b1, shreg[FW-1:1]};
                        bit_cnt   <= bit_cnt - 4'd1;
                    end else if (bus.ctrl_brk) begin
                        state     <= BREAK;
                        uart_tx_q <= 1'b0;
                    end else begin
                        state     <= IDLE;
                        uart_tx_q <= 1'b1;
                    end
                end
                BREAK: begin
                    if (!bus.ctrl_brk) begin
                        state     <= IDLE;
                        uart_tx_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    uart_tx_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx_count = count;
    assign bus.tx_nf    = !full;
    assign bus.tx_txe   = (count <= bus.ctrl_thr);
    assign bus.tx_busy  = (state != IDLE) || (count != '0);
    assign bus.tx_ovf   = ovf;
    assign bus.uart_tx  = uart_tx_q;
endmodule

// File: doc/uart_tx_gen2.md
Name: uart_tx_gen2

Overview:
Second-generation UART transmitter for the APB UART. It has a parametrised data width and FIFO depth, and runtime-selectable character length, parity mode and stop-bit count. It adds back-to-back framing with no idle gap, break generation and a sticky overflow flag. It sits between the APB register block, which drives the ctrl_* strobes and configuration, and the uart_tx pad; bit timing comes from the baud generator's one-cycle tick.

Parameters:
DATA_W, 8, maximum character width in bits; legal range 5 to 9.
FIFO_DEPTH, 16, TX FIFO entries; must be a power of 2 and at least 2.
AW, log2(FIFO_DEPTH), FIFO address width; derived, not overridden.

Ports:
pclk  in  1  single clock; all logic on its rising edge.
preset  in  1  reset, synchronous, active-high.
ctrl_en  in  1  transmitter enable; low flushes the FIFO and idles the line.
ctrl_wr  in  1  FIFO write strobe, one byte per cycle.
ctrl_data  in  DATA_W  write data.
ctrl_dbits  in  4  data bits per character; values below 5 are treated as 5, values above DATA_W are treated as DATA_W.
ctrl_par  in  2  parity mode: 00 none, 01 even, 10 odd, 11 stick-1.
ctrl_stop  in  1  stop bits: 0 means 1 stop bit, 1 means 2 stop bits.
ctrl_brk  in  1  break request.
ctrl_tick  in  1  bit-period strobe, one cycle wide.
ctrl_thr  in  AW+1  TX-empty threshold.
ctrl_ovf_clr  in  1  clears tx_ovf.
tx_count  out  AW+1  current FIFO occupancy.
tx_nf  out  1  FIFO not full.
tx_txe  out  1  high when tx_count <= ctrl_thr.
tx_busy  out  1  high when state != IDLE or tx_count != 0.
tx_ovf  out  1  sticky flag: a write arrived while the FIFO was full.
uart_tx  out  1  serial line; idles high.

Behaviour:
- Reset (preset=1 at an edge) values:
  - FIFO pointers 0, tx_count=0, tx_nf=1, tx_txe=1, tx_busy=0, tx_ovf=0.
  - state=IDLE, uart_tx=1, bit counter 0.
- FIFO:
  - Pointers are AW+1 bits wide and wrap naturally.
  - Full when the low AW bits are equal and the MSBs differ; empty when all bits are equal.
  - A write while full is dropped and sets tx_ovf at the next edge.
  - Full/empty are evaluated on pre-edge values. A write and a pop in the same cycle while full: the write is still dropped, and tx_count decrements by 1.
  - tx_ovf clears on ctrl_ovf_clr. If a set event and a clear arrive in the same cycle, set wins.
- Frame format: start(0), data bits LSB first (N = effective ctrl_dbits), optional parity bit, then 1 or 2 stop bits(1).
  - Even parity: the parity bit makes the count of ones over data+parity even. Odd parity makes that count odd. Stick-1 always sends 1.
- Configuration (ctrl_dbits, ctrl_par, ctrl_stop) is latched at frame load. Changes mid-frame take effect on the next frame only.
- State IDLE:
  - On ctrl_tick=1 with FIFO non-empty and ctrl_brk=0: pop the FIFO, load the shift register and go to SHIFT. uart_tx=0 from the next edge.
  - On ctrl_tick=1 with ctrl_brk=1: go to BREAK. The FIFO is not popped.
  - A write and a tick in the same cycle into an empty FIFO do not load; the load happens on the next tick.
- State SHIFT:
  - Each ctrl_tick advances one bit. Total bits per frame = 1+N+P+S, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
  - Each bit is held on uart_tx from one tick edge to the next.
  - On the tick that ends the last stop bit:
    - if ctrl_brk=1, go to BREAK;
    - else if the FIFO is non-empty, load the next frame on that same tick (start bit with no idle gap);
    - else go to IDLE with uart_tx=1.
- State BREAK: uart_tx=0. On a tick with ctrl_brk=0, go to IDLE with uart_tx=1.
- ctrl_en=0 (priority below preset, above everything else):
  - flush the FIFO (rptr is set to wptr, then both are cleared on the following cycles), giving tx_count=0;
  - state=IDLE, uart_tx=1, bit counter 0;
  - writes are ignored; tx_ovf is retained.
  - Dropping ctrl_en mid-frame aborts the frame at the next edge.
- Reset mid-frame behaves identically to ctrl_en=0, and additionally clears tx_ovf.
- Ticks arriving while IDLE with an empty FIFO and ctrl_brk=0 have no effect.

Test Plan:
- 8N1 (ctrl_dbits=8, ctrl_par=00, ctrl_stop=0): write 0xA5 and issue 10 ticks. Required uart_tx per bit: 0,1,0,1,0,0,1,0,1,1; then uart_tx=1, tx_busy=0, tx_count=0.
- 7E2 (ctrl_dbits=7, ctrl_par=01, ctrl_stop=1): write 0x41. Required uart_tx: 0,1,0,0,0,0,0,1, parity 0, stop 1,1. The frame is 11 ticks.
- Back-to-back: write 0x00 and 0xFF in 8N1. The frame boundary runs directly stop(1) then start(0) with no idle bit. Both frames complete in 20 ticks with no idle tick between them.
- Overflow (FIFO_DEPTH=16, no ticks): 17 writes. Required: tx_count=16, tx_nf=0, tx_ovf=1. Then ctrl_ovf_clr gives tx_ovf=0, and the 17th byte is never sent.
- Threshold: ctrl_thr=4. With 5 entries tx_txe=0; after one pop tx_txe=1. ctrl_thr=0 with 1 entry gives tx_txe=0.
- Break and abort:
  - ctrl_brk=1 during a frame: the frame completes, then uart_tx=0 until a tick with ctrl_brk=0, then uart_tx=1.
  - ctrl_en=0 at data bit 3: uart_tx=1 on the next edge, then tx_count=0 and state=IDLE.
